pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register with valid/ready handshake, an optional
//  2-entry skid buffer, and synchronous flush that loads a bubble value.

---
 rtl/pipe_stage_skid.sv | 105 ++++++++++
 tb/tb_pipe_stage_skid.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready) and synchronous flush-to-bubble.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(32'h0000_0013),
  parameter bit               SKID   = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Handshake: a beat moves on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and ready may be asserted without valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // state_q is the observable FSM state for checkers bound to this block.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          main_d  = in_data;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (in_valid) begin
            main_d = in_data;
          end else begin
            main_d  = BUBBLE;
            state_d = ST_EMPTY;
          end
        end else if (in_valid && SKID) begin
          // Stalled downstream: park the new beat until main drains.
          skid_d  = in_data;
          state_d = ST_SKID;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          main_d  = skid_q;
          skid_d  = BUBBLE;
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Without the skid entry, ready must look through to the downstream stall.
  assign in_ready  = SKID ? in_ready_q : (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance checked
// against a queue-based model of the beats each stage currently holds.
module tb_pipe_stage_skid;

  localparam int W = 32;
  localparam logic [W-1:0] BUBBLE = 32'h0000_0013;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   flush = '0;
  logic [1:0]   in_valid = '0;
  logic [1:0]   in_ready;
  logic [W-1:0] in_data[2];
  logic [1:0]   out_valid;
  logic [1:0]   out_ready = '0;
  logic [W-1:0] out_data[2];

  // Beats accepted but not yet delivered, oldest first; index 1 = SKID build.
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipe_stage_skid #(.WIDTH(W), .BUBBLE(BUBBLE), .SKID(1'b0)) dut_noskid (
    .clock(clock), .reset_n(reset_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
  );

  pipe_stage_skid #(.WIDTH(W), .BUBBLE(BUBBLE), .SKID(1'b1)) dut_skid (
    .clock(clock), .reset_n(reset_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
  );

  task automatic chk(input string name, input int s, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s skid=%0d got=%h exp=%h t=%0t", name, s, got, exp, $time);
    end
  endtask

  // Monitor for one stage: compare outputs with the held-beat model, then
  // advance the model by what happens at the coming rising edge.
  task automatic mon(input int s);
    logic [W-1:0] q[$];
    logic [W-1:0] beat;
    logic         exp_rdy;
    if (s == 1) q = exp_q1; else q = exp_q0;
    if (!reset_n) begin
      q.delete();
      chk("rst_out_valid", s, W'(out_valid[s]), W'(1'b0));
      chk("rst_out_data", s, out_data[s], BUBBLE);
      chk("rst_in_ready", s, W'(in_ready[s]), W'(1'b1));
    end else begin
      chk("out_valid", s, W'(out_valid[s]), W'(q.size() > 0));
      // Capacity is two beats with the skid entry, otherwise one.
      if (s == 1) exp_rdy = (q.size() < 2);
      else        exp_rdy = (q.size() == 0) || out_ready[s];
      chk("in_ready", s, W'(in_ready[s]), W'(exp_rdy));
      if (q.size() == 0) begin
        chk("bubble", s, out_data[s], BUBBLE);
      end else if (out_ready[s]) begin
        beat = q.pop_front();
        chk("beat", s, out_data[s], beat);
      end else begin
        chk("stall_hold", s, out_data[s], q[0]);
      end
      if (flush[s]) q.delete();
      else if (in_valid[s] && exp_rdy) q.push_back(in_data[s]);
    end
    if (s == 1) exp_q1 = q; else exp_q0 = q;
  endtask

  always @(negedge clock) begin
    mon(0);
    mon(1);
  end

  // Apply one cycle of identical stimulus to both stages.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                      input logic fl);
    in_valid  = {iv, iv};
    in_data[0] = d;
    in_data[1] = d;
    out_ready = {ordy, ordy};
    flush     = {fl, fl};
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_data[0] = '0;
    in_data[1] = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Streaming 1,2,3 back to back.
    step(1'b1, 32'd1, 1'b1, 1'b0);
    step(1'b1, 32'd2, 1'b1, 1'b0);
    step(1'b1, 32'd3, 1'b1, 1'b0);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Stall: A and B absorbed, C held off, then released in order.
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    repeat (2) step(1'b1, 32'h30, 1'b0, 1'b0);
    step(1'b1, 32'h30, 1'b1, 1'b0);
    step(1'b1, 32'h30, 1'b1, 1'b0);
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush while holding two beats with D offered: D must never appear.
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h30, 1'b0, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset while a beat is held.
    repeat (2) step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("async_out_valid", s, W'(out_valid[s]), W'(1'b0));
      chk("async_out_data", s, out_data[s], BUBBLE);
      chk("async_in_ready", s, W'(in_ready[s]), W'(1'b1));
    end
    in_valid = '0;
    out_ready = '0;
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Random traffic with independent stimulus per stage.
    for (int c = 0; c < 10000; c++) begin
      for (int s = 0; s < 2; s++) begin
        in_valid[s]  = ($urandom_range(0, 3) != 0);
        in_data[s]   = $urandom;
        out_ready[s] = ($urandom_range(0, 2) != 0);
        flush[s]     = ($urandom_range(0, 49) == 0);
      end
      @(posedge clock);
      #1;
    end

    // Drain and confirm nothing is left outstanding.
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    #1;
    chk("drained", 0, W'(exp_q0.size()), W'(0));
    chk("drained", 1, W'(exp_q1.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
